// File: rtl/spram_bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spram_bus_ctrl_pkg
// Shared definitions for the native-bus to single-port SRAM bridge:
//   - state_e : controller FSM states
//   - BUS_AW / BUS_DW / STRB_W : native bus address, data and strobe widths
// -----------------------------------------------------------------------------
package spram_bus_ctrl_pkg;

    localparam int unsigned BUS_AW = 32;
    localparam int unsigned BUS_DW = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        IDLE    = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/spram_bus_ctrl.sv
// -----------------------------------------------------------------------------
// spram_bus_ctrl
// Bridges the native valid/ready memory bus to a single-port SRAM wrapper.
// Optionally zero-fills the whole SRAM after reset before accepting traffic.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   mem_valid_i             bus request, held until mem_ready_o pulses
//   mem_addr_i              byte address, bits [ADDR_WIDTH+1:2] used
//   mem_wdata_i/mem_wstrb_i write data / byte strobes (0 = read)
//   mem_ready_o             registered one-cycle completion pulse
//   mem_rdata_o             registered read data, held between reads
//   init_done_o             high once the clear sweep has finished
//   sram_cs_o ... mask_o    combinational SRAM controls (all 0 when cs=0)
//   sram_rdata_i            SRAM read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module spram_bus_ctrl
    import spram_bus_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  mem_valid_i,
    input  logic [BUS_AW-1:0]     mem_addr_i,
    input  logic [BUS_DW-1:0]     mem_wdata_i,
    input  logic [STRB_W-1:0]     mem_wstrb_i,
    output logic                  mem_ready_o,
    output logic [BUS_DW-1:0]     mem_rdata_o,
    output logic                  init_done_o,
    output logic                  sram_cs_o,
    output logic                  sram_wren_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [BUS_DW-1:0]     sram_wdata_o,
    output logic [STRB_W-1:0]     sram_mask_o,
    input  logic [BUS_DW-1:0]     sram_rdata_i
);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  clr_cnt_q, clr_cnt_d;
    logic                   mem_ready_q, mem_ready_d;
    logic [BUS_DW-1:0]      mem_rdata_q, mem_rdata_d;
    logic                   init_done_q, init_done_d;

    // Address bits outside the word index are decoded upstream.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr_i[BUS_AW-1:ADDR_WIDTH+2], mem_addr_i[1:0]};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= INIT_CLEAR ? CLEAR : IDLE;
            clr_cnt_q   <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            init_done_q <= !INIT_CLEAR;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        mem_ready_d  = 1'b0;
        mem_rdata_d  = mem_rdata_q;
        init_done_d  = init_done_q;
        sram_cs_o    = 1'b0;
        sram_wren_o  = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_mask_o  = '0;

        case (state_q)
            CLEAR: begin
                sram_cs_o   = 1'b1;
                sram_wren_o = 1'b1;
                sram_mask_o = '1;
                sram_addr_o = clr_cnt_q;
                // Counter wraps back to 0 on the last word, ready for a later reset.
                clr_cnt_d   = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                if (mem_valid_i) begin
                    sram_cs_o   = 1'b1;
                    sram_addr_o = mem_addr_i[ADDR_WIDTH+1:2];
                    if (mem_wstrb_i != '0) begin
                        sram_wren_o  = 1'b1;
                        sram_wdata_o = mem_wdata_i;
                        sram_mask_o  = mem_wstrb_i;
                        state_d      = RESP;
                        mem_ready_d  = 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                mem_rdata_d = sram_rdata_i;
                mem_ready_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                // Ready is on this cycle; valid is deliberately not sampled here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_ready_o = mem_ready_q;
    assign mem_rdata_o = mem_rdata_q;
    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_spram_bus_ctrl.sv
module tb_spram_bus_ctrl;

    localparam int DEPTH = 1024;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        ready;
    logic [31:0] rdata;
    logic        init_done;
    logic        cs;
    logic        wren;
    logic [9:0]  saddr;
    logic [31:0] swdata;
    logic [3:0]  smask;
    logic [31:0] srdata;

    always #5 clk = ~clk;

    spram_bus_ctrl #(.ADDR_WIDTH(10), .INIT_CLEAR(1'b1)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .mem_valid_i  (valid),
        .mem_addr_i   (addr),
        .mem_wdata_i  (wdata),
        .mem_wstrb_i  (wstrb),
        .mem_ready_o  (ready),
        .mem_rdata_o  (rdata),
        .init_done_o  (init_done),
        .sram_cs_o    (cs),
        .sram_wren_o  (wren),
        .sram_addr_o  (saddr),
        .sram_wdata_o (swdata),
        .sram_mask_o  (smask),
        .sram_rdata_i (srdata)
    );

    // SRAM model: garbage preload on the first edge, then masked writes / 1-cycle reads
    logic [31:0] mem [DEPTH];
    bit          loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA5A5_0000 | i;
            loaded <= 1'b1;
        end else if (cs) begin
            if (wren) begin
                for (int b = 0; b < 4; b++)
                    if (smask[b]) mem[saddr][8*b +: 8] <= swdata[8*b +: 8];
            end else begin
                srdata <= mem[saddr];
            end
        end
    end

    // Bus/SRAM monitor, sampled 2 time units before each rising edge
    int   pcyc      = 0;
    int   clr_total = 0;
    int   clr_bad   = 0;
    int   cs_cnt    = 0;
    int   rdy_hi    = 0;
    int   rdy_dbl   = 0;
    logic rdy_prev  = 1'b0;

    always @(posedge clk) pcyc <= pcyc + 1;

    always @(negedge clk) begin
        #3;
        if (!rst_n) begin
            clr_total <= 0;
            clr_bad   <= 0;
            rdy_prev  <= 1'b0;
        end else begin
            if (!init_done && cs) begin
                if (!(wren && smask == 4'hF && swdata == 32'h0 && saddr == clr_total[9:0]))
                    clr_bad <= clr_bad + 1;
                clr_total <= clr_total + 1;
            end
            if (init_done && cs) cs_cnt <= cs_cnt + 1;
            if (ready) begin
                rdy_hi <= rdy_hi + 1;
                if (rdy_prev) rdy_dbl <= rdy_dbl + 1;
            end
            rdy_prev <= ready;
        end
    end

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One bus transaction; with hold=1 valid stays high so the caller can chain the next one.
    task automatic xact(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit hold, output int lat, output int at, output logic [31:0] rd,
                        output logic sw, output logic [9:0] sa, output logic [3:0] sm);
        addr  = a;
        wdata = d;
        wstrb = s;
        valid = 1'b1;
        #1;
        sw  = wren;
        sa  = saddr;
        sm  = smask;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!ready && lat < 10);
        rd = rdata;
        at = pcyc;
        if (!hold) begin
            valid = 1'b0;
            addr  = '0;
            wdata = '0;
            wstrb = '0;
            step();
        end
    endtask

    initial begin
        int          n;
        int          lat;
        int          at;
        int          t0;
        int          t1;
        int          t2;
        int          c0;
        int          r0;
        int          nz;
        bit          early;
        logic [31:0] rd;
        logic        sw;
        logic [9:0]  sa;
        logic [3:0]  sm;

        repeat (3) step();
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_init_done", {31'b0, init_done}, 32'd0);
        chk("rst_clr_cs", {31'b0, cs}, 32'd1);
        chk("rst_clr_addr", {22'b0, saddr}, 32'd0);

        // Initial clear sweep
        rst_n = 1'b1;
        n = 0;
        while (!init_done && n < 2000) begin
            step();
            n++;
        end
        chk("sweep_cycles", n, 32'd1024);
        chk("sweep_selects", clr_total, 32'd1024);
        chk("sweep_bad_selects", clr_bad, 32'd0);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== 32'h0) nz++;
        chk("sweep_nonzero_words", nz, 32'd0);
        chk("idle_cs", {31'b0, cs}, 32'd0);
        chk("idle_addr", {22'b0, saddr}, 32'd0);
        chk("idle_mask", {28'b0, smask}, 32'd0);

        // Reads after clear at both ends of the array
        xact(32'h0000_0000, 32'h0, 4'h0, 1'b0, lat, at, rd, sw, sa, sm);
        chk("rd0_data", rd, 32'h0);
        chk("rd0_lat", lat, 32'd2);
        xact(32'h0000_0FFC, 32'h0, 4'h0, 1'b0, lat, at, rd, sw, sa, sm);
        chk("rdffc_addr", {22'b0, sa}, 32'd1023);
        chk("rdffc_data", rd, 32'h0);

        // Full word write then read back
        xact(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, lat, at, rd, sw, sa, sm);
        chk("wr10_addr", {22'b0, sa}, 32'd4);
        chk("wr10_mask", {28'b0, sm}, 32'hF);
        chk("wr10_wren", {31'b0, sw}, 32'd1);
        chk("wr10_lat", lat, 32'd1);
        xact(32'h0000_0010, 32'h0, 4'h0, 1'b0, lat, at, rd, sw, sa, sm);
        chk("rd10_data", rd, 32'hDEAD_BEEF);
        chk("rd10_lat", lat, 32'd2);
        chk("rd10_wren", {31'b0, sw}, 32'd0);

        // Byte write; rdata must keep the last read value across a write
        xact(32'h0000_0010, 32'h0000_AA00, 4'b0010, 1'b0, lat, at, rd, sw, sa, sm);
        chk("bw_mask", {28'b0, sm}, 32'h2);
        chk("bw_rdata_held", rd, 32'hDEAD_BEEF);
        xact(32'h0000_0013, 32'h0, 4'h0, 1'b0, lat, at, rd, sw, sa, sm);
        chk("bw_rd_addr", {22'b0, sa}, 32'd4);
        chk("bw_rd_data", rd, 32'hDEAD_AAEF);

        // 4 KB aliasing
        xact(32'h0000_1004, 32'h1234_5678, 4'hF, 1'b0, lat, at, rd, sw, sa, sm);
        chk("alias_wr_addr", {22'b0, sa}, 32'd1);
        xact(32'h0000_0004, 32'h0, 4'h0, 1'b0, lat, at, rd, sw, sa, sm);
        chk("alias_rd_data", rd, 32'h1234_5678);

        // valid dropped after acceptance: access still completes
        addr  = 32'h0000_0010;
        wstrb = 4'h0;
        valid = 1'b1;
        step();
        valid = 1'b0;
        n = 0;
        while (!ready && n < 10) begin
            step();
            n++;
        end
        chk("drop_valid_lat", n, 32'd1);
        chk("drop_valid_data", rdata, 32'hDEAD_AAEF);
        step();

        // Back-to-back write/read/write with valid held high
        c0 = cs_cnt;
        r0 = rdy_hi;
        xact(32'h0000_0020, 32'hCAFE_F00D, 4'hF, 1'b1, lat, t0, rd, sw, sa, sm);
        chk("b2b_w0_lat", lat, 32'd1);
        xact(32'h0000_0020, 32'h0, 4'h0, 1'b1, lat, t1, rd, sw, sa, sm);
        chk("b2b_r_lat", lat, 32'd3);
        chk("b2b_r_data", rd, 32'hCAFE_F00D);
        xact(32'h0000_0024, 32'h55AA_55AA, 4'hF, 1'b0, lat, t2, rd, sw, sa, sm);
        chk("b2b_w1_lat", lat, 32'd2);
        chk("b2b_gap_wr_rd", t1 - t0, 32'd3);
        chk("b2b_gap_rd_wr", t2 - t1, 32'd2);
        chk("b2b_cs_pulses", cs_cnt - c0, 32'd3);
        chk("b2b_ready_pulses", rdy_hi - r0, 32'd3);
        chk("ready_width", rdy_dbl, 32'd0);

        // Reset mid-sweep, then a request pending across the restarted sweep
        rst_n = 1'b0;
        #1;
        chk("rst2_rdata", rdata, 32'd0);
        chk("rst2_init_done", {31'b0, init_done}, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (500) step();
        chk("clr_at_500", {22'b0, saddr}, 32'd500);
        rst_n = 1'b0;
        addr  = 32'h0000_0010;
        wstrb = 4'h0;
        valid = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        n = 0;
        early = 1'b0;
        while (!init_done && n < 2000) begin
            step();
            n++;
            if (ready && !init_done) early = 1'b1;
        end
        chk("resweep_cycles", n, 32'd1024);
        chk("resweep_selects", clr_total, 32'd1024);
        chk("resweep_bad_selects", clr_bad, 32'd0);
        chk("pending_no_early_ready", {31'b0, early}, 32'd0);
        n = 0;
        while (!ready && n < 10) begin
            step();
            n++;
        end
        chk("pending_lat", n, 32'd2);
        chk("pending_data", rdata, 32'h0);
        valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule

// File: doc/spram_bus_ctrl.md
Name: spram_bus_ctrl

Overview:
- Bridges the SoC native memory bus (valid/ready, byte strobes, picorv32-style) to one 1024x32 single-port on-chip SRAM macro wrapper.
- Sits directly upstream of the SRAM. Issues single-cycle chip-select accesses and registers the read data back to the bus.
- Optionally zero-fills the whole SRAM after reset, before it accepts any bus traffic.

Parameters:
- ADDR_WIDTH, 10, SRAM word-address width. Depth is 2**ADDR_WIDTH words.
- INIT_CLEAR, 1, 1 = zero-fill the SRAM after reset; 0 = go straight to idle.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- mem_valid_i  in  1  bus request; held until mem_ready_o pulses.
- mem_addr_i  in  32  byte address; only bits [ADDR_WIDTH+1:2] are used.
- mem_wdata_i  in  32  write data.
- mem_wstrb_i  in  4  byte strobes; 0 = read, nonzero = write.
- mem_ready_o  out  1  one-cycle completion pulse, registered.
- mem_rdata_o  out  32  read data, registered, valid while mem_ready_o=1.
- init_done_o  out  1  high once the clear sweep has finished (or immediately if INIT_CLEAR=0).
- sram_cs_o  out  1  SRAM chip select.
- sram_wren_o  out  1  1 = write, 0 = read.
- sram_addr_o  out  ADDR_WIDTH  SRAM word address.
- sram_wdata_o  out  32  SRAM write data.
- sram_mask_o  out  4  byte write enables.
- sram_rdata_i  in  32  SRAM read data, valid on the cycle after a read-select.

Behaviour:
- Reset values (asynchronous):
  - state = CLEAR if INIT_CLEAR=1, else IDLE.
  - clr_cnt = 0.
  - mem_ready_o = 0, mem_rdata_o = 0.
  - init_done_o = !INIT_CLEAR.
- SRAM outputs are combinational from state and bus inputs. When cs=0: wren=0, addr=0, wdata=0, mask=0.
- CLEAR state:
  - Drives cs=1, wren=1, mask=4'hF, wdata=0, addr=clr_cnt.
  - clr_cnt increments every cycle. At clr_cnt = 2**ADDR_WIDTH-1 the FSM moves to IDLE, and init_done_o rises on that same edge. Total sweep is 1024 cycles at the default size.
  - mem_ready_o stays 0 and mem_valid_i is ignored. A request pending during the sweep is serviced once IDLE is reached.
- IDLE state, on mem_valid_i=1 (cycle T):
  - Write (wstrb!=0):
    - Drives cs=1, wren=1, addr=mem_addr_i[ADDR_WIDTH+1:2], wdata=mem_wdata_i, mask=mem_wstrb_i.
    - Moves to RESP; mem_ready_o=1 in cycle T+1.
  - Read (wstrb==0):
    - Drives cs=1, wren=0, addr as above; moves to RD_WAIT.
  - mem_valid_i=0: cs=0, stay in IDLE.
- RD_WAIT state (T+1):
  - cs=0; mem_rdata_o <= sram_rdata_i; moves to RESP.
  - mem_ready_o=1 in cycle T+2.
- RESP state:
  - mem_ready_o=1 for exactly one cycle, cs=0, then IDLE.
  - mem_valid_i is not sampled in RESP, so a request is never issued twice.
  - Earliest next accept is the cycle after the ready pulse.
- Latency: write 1 cycle, read 2 cycles, measured from valid-sampled to ready-high. Back-to-back throughput: write every 2 cycles, read every 3.
- mem_rdata_o holds its last captured value between reads. Writes do not update it.
- Address handling:
  - Address bits above ADDR_WIDTH+1 are ignored, so addresses alias modulo 4 KB; decode happens upstream.
  - Bits [1:0] are ignored.
- If mem_valid_i drops mid-transaction (a protocol violation), the access still completes and ready still pulses.
- Reset asserted at any point aborts the current access. With INIT_CLEAR=1 the sweep restarts from word 0.
- Unreachable state encodings recover to IDLE.

Decomposition:
- Package spram_bus_ctrl_pkg holds:
  - state enum: CLEAR, IDLE, RD_WAIT, RESP.
  - constants: BUS_AW=32, BUS_DW=32, STRB_W=4.
- No sub-module; the clear counter and FSM live in one module. The SRAM wrapper is instantiated by the parent, not inside this block.

Test Plan:
- Reset with INIT_CLEAR=1, then preload garbage in the SRAM model -> exactly 1024 write-selects with mask F, data 0, addr 0..1023; init_done_o rises at cycle 1024; reads of 0x000 and 0xFFC both return 0.
- Write addr 0x10, data 0xDEADBEEF, wstrb F -> sram addr 4, mask F; mem_ready_o at T+1. Read of 0x10 then returns 0xDEADBEEF with ready at T+2.
- Byte write addr 0x10, data 0x0000AA00, wstrb 4'b0010 -> mask 0010; subsequent read returns 0xDEADAAEF.
- Alias check: write 0x1004 with 0x12345678 -> sram addr 1; read of 0x0004 returns 0x12345678. Read of 0xFFC drives sram addr 1023.
- Back-to-back: write/read/write streams with valid held high -> exactly one cs pulse per transaction; ready pulses 1 cycle wide at the 2/3/2-cycle spacing.
- Reset asserted at clear count 500 and released -> sweep restarts at addr 0 and takes a full 1024 cycles; a request pending during the sweep gets ready only after init_done_o=1.
